assoc_cache: RTL
================

# assoc_cache

Parametrised N-way set-associative, write-back, write-allocate data cache. It sits between the CPU load/store port and the line-granular main memory. It generalises the lab cache in four ways: any way count, a run-time-free choice of FIFO or LRU replacement, byte-enabled writes, and an external memory port that is not instantiated inside the block. Miss handling uses the IDLE / SWAP_OUT / SWAP_IN / SWAP_IN_OK sequence with a `gnt` handshake to memory.

## Interface
- `LINE_ADDR_LEN`, 3: log2 of words per line.
- `SET_ADDR_LEN`, 3: log2 of set count.
- `TAG_ADDR_LEN`, 6: tag width. Address bits above the tag are ignored.
- `WAY_CNT`, 4: ways per set, 1..16, any integer.
- `REPL_LRU`, 0: 0 = FIFO, 1 = LRU.
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-high reset.
- `addr` in 32: byte address, split as {unused, tag, set, line, 2'b word}.
- `rd_req` in 1: read request. Wins over `wr_req` if both are high.
- `wr_req` in 1: write request.
- `wr_data` in 32: write data.
- `wr_be` in 4: byte enables for writes.
- `rd_data` out 32: registered read data.
- `miss` out 1: combinational stall, high = CPU must hold its request.
- `mem_rd_req` out 1: line read request.
- `mem_wr_req` out 1: line write request.
- `mem_addr` out TAG+SET: line address.
- `mem_wr_line` out 32·2^LINE_ADDR_LEN: victim line, word 0 in the LSBs.
- `mem_rd_line` in 32·2^LINE_ADDR_LEN: fill line.
- `mem_gnt` in 1: memory completion pulse.

## Operation
- Hit:
  - A way hits when `valid[set][w] && tag[set][w]==tag`.
  - Ways are searched in parallel. The lowest matching index wins; duplicates must never arise.
- `miss = (rd_req|wr_req) & ~(state==IDLE & hit)`.
- Read hit in IDLE: `rd_data` ← word at the next edge.
- Write hit in IDLE:
  - Each byte with `wr_be[b]` set is written.
  - `dirty` is set, even when `wr_be==0`.
- Miss in IDLE with a request:
  - Victim selection: the lowest-index invalid way; otherwise the way with age == WAY_CNT-1.
  - The victim index and request tag/set are latched.
  - Go to SWAP_OUT if the victim is valid and dirty, else to SWAP_IN.
- SWAP_OUT:
  - `mem_wr_req=1`, `mem_addr`={victim tag, set}, `mem_wr_line` = latched victim data.
  - Stay until `mem_gnt`, then go to SWAP_IN.
- SWAP_IN:
  - `mem_rd_req=1`, `mem_addr`={latched tag, set}.
  - Stay until `mem_gnt`, then go to SWAP_IN_OK.
- SWAP_IN_OK:
  - Write the fill line, tag, `valid=1`, `dirty=0` into the latched way.
  - Count the fill as an access (see ages below).
  - Go to IDLE. The held request then hits.
- Ages:
  - Per way, width max(1, clog2(WAY_CNT)). Within each set the ages always form a permutation of 0..WAY_CNT-1.
  - Reset value: `age[s][w]=w`.
  - Access to way v: `age[v]←0`. Every way with `age < old age[v]` increments.
  - FIFO: only fills are accesses.
  - LRU: fills plus every IDLE cycle with a request and a hit.
- Memory request outputs are decoded from state only. `mem_addr` is 0 in IDLE and SWAP_IN_OK.
- Reset (any time, including mid-miss):
  - State → IDLE; `valid`/`dirty` cleared; ages restored.
  - `rd_data`, `mem_wr_line` → 0.
  - `miss`, `mem_rd_req`, `mem_wr_req` low immediately while no request is present.
  - Data and tag arrays are not reset.

## Timing
- Hit latency: 0 stall cycles; `rd_data` is valid after the edge following the request.
- Clean miss: 1 (IDLE) + SWAP_IN cycles until `gnt` + 1 (SWAP_IN_OK) + 1 (hit), i.e. ≥ 4 edges with a one-cycle memory.
- Dirty miss adds the SWAP_OUT cycles.
- `mem_gnt` is sampled only in SWAP_OUT/SWAP_IN and ignored elsewhere.
- The request must be held stable while `miss=1`. Behaviour on address change mid-miss: the latched line is still filled; the new address is then evaluated in IDLE.

## Configuration
- `ASSOC_CACHE_STATS_EN` defined:
  - Adds outputs `hit_cnt` and `miss_cnt`, 32 bit, reset 0, wrapping.
  - `hit_cnt` increments per IDLE cycle with a request and a hit.
  - `miss_cnt` increments once per IDLE→SWAP_OUT/SWAP_IN transition.
- Undefined: the ports and counters are absent. Behaviour is otherwise identical.

## Structure
- Package `cache_pkg`:
  - state enum {IDLE, SWAP_OUT, SWAP_IN, SWAP_IN_OK};
  - `REPL_FIFO`/`REPL_LRU` constants;
  - a function computing age width.
- Sub-module `cache_repl`:
  - Per-set age arrays, victim select, access update.
  - Inputs: set, hit way, access strobe, invalid mask.
  - Output: victim way.

## Test plan
- `WAY_CNT=4`, FIFO; read addresses 0x000, 0x100, 0x200, 0x300, 0x400 (all set 0).
  - Four clean fills into ways 0..3. The fifth evicts way 0.
  - A read of 0x000 then misses again.
- Same sequence with LRU, plus a read of 0x000 before 0x400.
  - 0x100 is evicted. 0x000 still hits (`miss=0` same cycle).
- Write 0xDEADBEEF with `wr_be=4'b0101` to a cached word holding 0x11223344.
  - Read returns 0x11AD33EF and `dirty` is set.
  - Eviction then pulses `mem_wr_req` with that word, before `mem_rd_req`.
- Assert `rst` while in SWAP_IN with `mem_rd_req` high.
  - `mem_rd_req` drops the same cycle, state is IDLE, and a prior hit address now misses.
- `rd_req` and `wr_req` both high on a hit: `rd_data` is updated and the word/dirty are unchanged.
- With `ASSOC_CACHE_STATS_EN`, 3 misses then 5 hit cycles:
  - `miss_cnt=3`;
  - `hit_cnt` = 5 + 3 (post-fill hits) = 8.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and constants for the set-associative cache.
package cache_pkg;

    // Miss-handling sequence.
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SWAP_OUT   = 2'd1,
        SWAP_IN    = 2'd2,
        SWAP_IN_OK = 2'd3
    } state_t;

    // Replacement policy selectors.
    localparam int REPL_FIFO = 0;
    localparam int REPL_LRU  = 1;

    // Width of a per-way age (and of a way index); at least one bit.
    function automatic int age_width(input int way_cnt);
        return (way_cnt > 1) ? $clog2(way_cnt) : 1;
    endfunction

endpackage

// File: rtl/cache_repl.sv
// Per-set age tracking and victim selection for the cache.
// Ages of the ways in a set always form a permutation of 0..WAY_CNT-1;
// the oldest valid way (age WAY_CNT-1) is replaced once no way is invalid.
module cache_repl
    import cache_pkg::*;
#(
    parameter int SET_ADDR_LEN = 3,
    parameter int WAY_CNT      = 4,
    localparam int WAY_W       = age_width(WAY_CNT)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SET_ADDR_LEN-1:0] set,
    input  logic [WAY_W-1:0]        hit_way,
    input  logic                    access,
    input  logic [WAY_CNT-1:0]      invalid_mask,
    output logic [WAY_W-1:0]        victim_way
);

    localparam int SETS = 1 << SET_ADDR_LEN;

    logic [WAY_W-1:0] age [SETS][WAY_CNT];

    // Age update: accessed way becomes youngest, younger ways shift up by one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAY_CNT; w++)
                    age[s][w] <= WAY_W'(w);
        end else if (access) begin
            // NOTE: non-blocking updates make every comparison below see the
            // pre-access ages, so the order of the loop iterations is irrelevant.
            for (int w = 0; w < WAY_CNT; w++) begin
                if (WAY_W'(w) == hit_way)
                    age[set][w] <= '0;
                else if (age[set][w] < age[set][hit_way])
                    age[set][w] <= age[set][w] + 1'b1;
            end
        end
    end

    // Victim: lowest invalid way, otherwise the oldest way of the set.
    always_comb begin
        logic found;
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        victim_way = '0;
        found      = 1'b0;
        for (int w = 0; w < WAY_CNT; w++) begin
            if (!found && invalid_mask[w]) begin
                victim_way = WAY_W'(w);
                found      = 1'b1;
            end
        end
        if (!found) begin
            for (int w = 0; w < WAY_CNT; w++)
                if (age[set][w] == WAY_W'(WAY_CNT - 1))
                    victim_way = WAY_W'(w);
        end
    end

endmodule

// File: rtl/assoc_cache.sv
// N-way set-associative, write-back, write-allocate data cache.
// Optional hit/miss counters are enabled by defining ASSOC_CACHE_STATS_EN.
module assoc_cache #(
    parameter int LINE_ADDR_LEN = 3,
    parameter int SET_ADDR_LEN  = 3,
    parameter int TAG_ADDR_LEN  = 6,
    parameter int WAY_CNT       = 4,
    parameter int REPL_LRU      = 0
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [31:0]                            addr,
    input  logic                                   rd_req,
    input  logic                                   wr_req,
    input  logic [31:0]                            wr_data,
    input  logic [3:0]                             wr_be,
    output logic [31:0]                            rd_data,
    output logic                                   miss,
    output logic                                   mem_rd_req,
    output logic                                   mem_wr_req,
    output logic [TAG_ADDR_LEN+SET_ADDR_LEN-1:0]   mem_addr,
    output logic [32*(1<<LINE_ADDR_LEN)-1:0]       mem_wr_line,
    input  logic [32*(1<<LINE_ADDR_LEN)-1:0]       mem_rd_line,
    input  logic                                   mem_gnt
`ifdef ASSOC_CACHE_STATS_EN
    ,
    output logic [31:0]                            hit_cnt,
    output logic [31:0]                            miss_cnt
`endif
);

    import cache_pkg::*;

    localparam int WORDS    = 1 << LINE_ADDR_LEN;
    localparam int SETS     = 1 << SET_ADDR_LEN;
    localparam int WAY_W    = age_width(WAY_CNT);
    localparam int LINE_W   = 32 * WORDS;
    localparam bit LRU_MODE = (REPL_LRU != REPL_FIFO);

    // Address fields: {unused, tag, set, word-in-line, byte}.
    logic [LINE_ADDR_LEN-1:0] word_idx;
    logic [SET_ADDR_LEN-1:0]  set_idx;
    logic [TAG_ADDR_LEN-1:0]  tag_in;
    logic                     addr_unused;
    assign word_idx    = addr[LINE_ADDR_LEN+1 -: LINE_ADDR_LEN];
    assign set_idx     = addr[SET_ADDR_LEN+LINE_ADDR_LEN+1 -: SET_ADDR_LEN];
    assign tag_in      = addr[TAG_ADDR_LEN+SET_ADDR_LEN+LINE_ADDR_LEN+1 -: TAG_ADDR_LEN];
    assign addr_unused = ^addr;

    logic [31:0]             data_mem [SETS][WAY_CNT][WORDS];
    logic [TAG_ADDR_LEN-1:0] tag_mem  [SETS][WAY_CNT];
    logic [WAY_CNT-1:0]      valid_q  [SETS];
    logic [WAY_CNT-1:0]      dirty_q  [SETS];

    state_t                  state, state_d;
    logic [WAY_W-1:0]        victim_q;
    logic [TAG_ADDR_LEN-1:0] tag_q, victim_tag_q;
    logic [SET_ADDR_LEN-1:0] set_q;

    logic              req, hit, idle_hit, write_hit, start_miss;
    logic [WAY_W-1:0]  hit_way, victim_way, repl_way;
    logic [SET_ADDR_LEN-1:0] repl_set;
    logic              repl_access;
    logic [LINE_W-1:0] victim_line;

    assign req        = rd_req | wr_req;
    assign idle_hit   = (state == IDLE) & hit;
    assign write_hit  = idle_hit & wr_req & ~rd_req;
    assign start_miss = (state == IDLE) & req & ~hit;

    // Parallel tag compare; the lowest matching way wins.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = WAY_CNT - 1; w >= 0; w--) begin
            if (valid_q[set_idx][w] && tag_mem[set_idx][w] == tag_in) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Gather the candidate victim line, word 0 in the LSBs.
    always_comb begin
        victim_line = '0;
        for (int i = 0; i < WORDS; i++)
            victim_line[32*i +: 32] = data_mem[set_idx][victim_way][i];
    end

    // Fills always count as accesses; hits only under LRU.
    assign repl_set    = (state == SWAP_IN_OK) ? set_q : set_idx;
    assign repl_way    = (state == SWAP_IN_OK) ? victim_q : hit_way;
    assign repl_access = (state == SWAP_IN_OK) | (LRU_MODE & idle_hit & req);

    cache_repl #(
        .SET_ADDR_LEN (SET_ADDR_LEN),
        .WAY_CNT      (WAY_CNT)
    ) u_repl (
        .clk          (clk),
        .rst          (rst),
        .set          (repl_set),
        .hit_way      (repl_way),
        .access       (repl_access),
        .invalid_mask (~valid_q[set_idx]),
        .victim_way   (victim_way)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // Next state and state-decoded memory port / stall outputs.
    always_comb begin
        state_d    = state;
        mem_rd_req = 1'b0;
        mem_wr_req = 1'b0;
        mem_addr   = '0;
        miss       = req & ~idle_hit;
        case (state)
            IDLE: begin
                if (start_miss)
                    state_d = (valid_q[set_idx][victim_way] && dirty_q[set_idx][victim_way])
                              ? SWAP_OUT : SWAP_IN;
            end
            SWAP_OUT: begin
                mem_wr_req = 1'b1;
                mem_addr   = {victim_tag_q, set_q};
                if (mem_gnt) state_d = SWAP_IN;
            end
            SWAP_IN: begin
                mem_rd_req = 1'b1;
                mem_addr   = {tag_q, set_q};
                if (mem_gnt) state_d = SWAP_IN_OK;
            end
            SWAP_IN_OK: state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // Latch the miss context: victim way, request line and victim contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            victim_q     <= '0;
            tag_q        <= '0;
            set_q        <= '0;
            victim_tag_q <= '0;
            mem_wr_line  <= '0;
        end else if (start_miss) begin
            victim_q     <= victim_way;
            tag_q        <= tag_in;
            set_q        <= set_idx;
            victim_tag_q <= tag_mem[set_idx][victim_way];
            mem_wr_line  <= victim_line;
        end
    end

    // Valid/dirty bits: set on fill, dirty on any write hit (even with no byte enabled).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
            end
        end else if (state == SWAP_IN_OK) begin
            valid_q[set_q][victim_q] <= 1'b1;
            dirty_q[set_q][victim_q] <= 1'b0;
        end else if (write_hit) begin
            dirty_q[set_idx][hit_way] <= 1'b1;
        end
    end

    // Data and tag storage: line fill or byte-enabled write hit.
    // NOTE: the arrays have no reset; the valid bits alone decide whether
    // their contents mean anything, so they map onto plain RAM.
    always_ff @(posedge clk) begin
        if (state == SWAP_IN_OK) begin
            for (int i = 0; i < WORDS; i++)
                data_mem[set_q][victim_q][i] <= mem_rd_line[32*i +: 32];
            tag_mem[set_q][victim_q] <= tag_q;
        end else if (write_hit) begin
            for (int b = 0; b < 4; b++)
                if (wr_be[b])
                    data_mem[set_idx][hit_way][word_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
    end

    // Registered read data on a read hit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 rd_data <= '0;
        else if (idle_hit && rd_req) rd_data <= data_mem[set_idx][hit_way][word_idx];
    end

`ifdef ASSOC_CACHE_STATS_EN
    // Wrapping hit/miss counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (idle_hit && req) hit_cnt  <= hit_cnt + 32'd1;
            if (start_miss)      miss_cnt <= miss_cnt + 32'd1;
        end
    end
`endif

endmodule
